// File: rtl/fisc_fetch_unit.sv
// fisc_fetch_unit: FISC instruction fetch stage; owns the PC, reads the 64-bit bus and hands 32-bit instructions to decode.
//   clk, reset                     : clock, synchronous active-high reset
//   wait_n, d_in                   : bus ready and read data
//   a, rd_n, opcycle_n             : bus address (8-byte aligned) and active-low strobes
//   instr, instr_pc, instr_valid   : instruction to decode, its byte address, valid
//   instr_ready                    : decode accepts this cycle
//   redirect_valid, redirect_pc    : PC redirect from execute/writeback
//   fault, fault_code              : latched fetch fault (01 misaligned redirect, 10 bus timeout)
module fisc_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wait_n,
   input  logic [63:0] d_in,
   output logic [63:0] a,
   output logic        rd_n,
   output logic        opcycle_n,
   output logic [31:0] instr,
   output logic [63:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        fault,
   output logic [1:0]  fault_code
);
   typedef enum logic [2:0] {COLD, BUS, VALID, GAP, FAULT} state_t;
   state_t      state;
   logic [63:0] pc;
   logic [15:0] cnt;
   assign a           = state == BUS ? {pc[63:3], 3'b000} : '0;
   assign rd_n        = state != BUS;
   assign opcycle_n   = state != BUS;
   assign instr_valid = state == VALID;
   assign fault       = state == FAULT;
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= COLD;
         pc         <= RESET_PC;
         instr      <= '0;
         instr_pc   <= '0;
         cnt        <= '0;
         fault_code <= 2'b00;
      end else if (redirect_valid && state != COLD) begin
         // redirect abandons any in-flight read or pending instruction
         if (redirect_pc[1:0] == 2'b00) begin
            pc         <= redirect_pc;
            fault_code <= 2'b00;
            state      <= GAP;
         end else begin
            fault_code <= 2'b01;
            state      <= FAULT;
         end
      end else begin
         case (state)
            COLD: begin
               cnt   <= '0;
               state <= BUS;
            end
            BUS:
               if (wait_n) begin
                  instr    <= pc[2] ? d_in[63:32] : d_in[31:0];
                  instr_pc <= pc;
                  state    <= VALID;
               end else if (cnt == 16'(TIMEOUT - 1)) begin
                  fault_code <= 2'b10;
                  state      <= FAULT;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            VALID:
               if (instr_ready) begin
                  pc    <= pc + 64'd4;
                  cnt   <= '0;
                  state <= BUS;
               end
            GAP: begin
               cnt   <= '0;
               state <= BUS;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fisc_fetch_unit.sv
// tb_fisc_fetch_unit: directed bench for fisc_fetch_unit with a scoreboard of accepted instructions.
module tb_fisc_fetch_unit;
   logic        clk = 0;
   logic        reset = 1;
   logic        wait_n = 1;
   logic [63:0] d_in;
   logic [63:0] a;
   logic        rd_n, opcycle_n, instr_valid, fault;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        instr_ready = 1;
   logic        redirect_valid = 0;
   logic [63:0] redirect_pc = '0;
   logic [1:0]  fault_code;
   int          compared = 0;
   int          mismatched = 0;
   logic [63:0] q[$];

   fisc_fetch_unit #(.RESET_PC(64'h0), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .wait_n(wait_n), .d_in(d_in), .a(a), .rd_n(rd_n),
      .opcycle_n(opcycle_n), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fault(fault), .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] memword(input logic [63:0] addr);
      return addr == 64'h0 ? 64'hAAAA_BBBB_1111_2222
                           : {32'hC000_0000 | (addr[31:0] + 32'd4), 32'hC000_0000 | addr[31:0]};
   endfunction

   function automatic logic [31:0] exp_instr(input logic [63:0] p);
      return p[63:3] == 61'h0 ? (p[2] ? 32'hAAAA_BBBB : 32'h1111_2222) : (32'hC000_0000 | p[31:0]);
   endfunction

   assign d_in = memword(a);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic arm(input logic [63:0] base);
      q.delete();
      for (int i = 0; i < 16; i++) q.push_back(base + 64'(4 * i));
   endtask

   task automatic chk_reset_outs();
      chk("rst_a", a, 64'h0);
      chk("rst_rd_n", 64'(rd_n), 64'h1);
      chk("rst_opcycle_n", 64'(opcycle_n), 64'h1);
      chk("rst_valid", 64'(instr_valid), 64'h0);
      chk("rst_fault", 64'(fault), 64'h0);
      chk("rst_code", 64'(fault_code), 64'h0);
      chk("rst_instr", 64'(instr), 64'h0);
      chk("rst_instr_pc", instr_pc, 64'h0);
   endtask

   // scoreboard: every accepted (non-squashed) instruction must be the next expected PC
   always @(negedge clk) begin
      if (!reset && instr_valid && instr_ready && !redirect_valid) begin
         if (q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL sb_empty observed=%h expected=none", instr_pc);
         end else begin
            logic [63:0] e;
            e = q.pop_front();
            chk("sb_pc", instr_pc, e);
            chk("sb_instr", 64'(instr), 64'(exp_instr(e)));
         end
      end
   end

   initial begin
      tick();
      tick();
      chk_reset_outs();
      reset = 0;
      arm(64'h0);
      tick();
      chk("c1_rd_n", 64'(rd_n), 64'h0);
      chk("c1_opcycle_n", 64'(opcycle_n), 64'h0);
      chk("c1_a", a, 64'h0);
      tick();
      chk("c2_valid", 64'(instr_valid), 64'h1);
      chk("c2_instr", 64'(instr), 64'h1111_2222);
      chk("c2_pc", instr_pc, 64'h0);
      tick();
      chk("c3_rd_n", 64'(rd_n), 64'h0);
      chk("c3_a", a, 64'h0);
      tick();
      chk("c4_instr", 64'(instr), 64'hAAAA_BBBB);
      chk("c4_pc", instr_pc, 64'h4);
      tick();
      chk("c5_a", a, 64'h8);
      reset = 1;
      tick();
      chk_reset_outs();
      reset = 0;
      wait_n = 0;
      arm(64'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("ws_rd_n", 64'(rd_n), 64'h0);
         chk("ws_a", a, 64'h0);
         chk("ws_fault", 64'(fault), 64'h0);
         if (i < 3) tick();
      end
      wait_n = 1;
      instr_ready = 0;
      tick();
      chk("ws_valid", 64'(instr_valid), 64'h1);
      chk("ws_instr", 64'(instr), 64'h1111_2222);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", 64'(instr_valid), 64'h1);
         chk("bp_rd_n", 64'(rd_n), 64'h1);
         chk("bp_instr", 64'(instr), 64'h1111_2222);
         chk("bp_pc", instr_pc, 64'h0);
      end
      instr_ready = 1;
      tick();
      chk("bp_bus_a", a, 64'h0);
      tick();
      chk("bp_next_pc", instr_pc, 64'h4);
      tick();
      chk("rd_bus_a", a, 64'h8);
      wait_n = 0;
      redirect_valid = 1;
      redirect_pc = 64'h100;
      arm(64'h100);
      tick();
      chk("gap_rd_n", 64'(rd_n), 64'h1);
      chk("gap_valid", 64'(instr_valid), 64'h0);
      redirect_valid = 0;
      wait_n = 1;
      tick();
      chk("rd_new_a", a, 64'h100);
      tick();
      chk("rd_new_pc", instr_pc, 64'h100);
      chk("rd_new_instr", 64'(instr), 64'hC000_0100);
      redirect_valid = 1;
      redirect_pc = 64'h102;
      tick();
      chk("mis_fault", 64'(fault), 64'h1);
      chk("mis_code", 64'(fault_code), 64'h1);
      chk("mis_rd_n", 64'(rd_n), 64'h1);
      redirect_valid = 0;
      tick();
      chk("mis_hold", 64'(fault_code), 64'h1);
      chk("mis_hold_valid", 64'(instr_valid), 64'h0);
      redirect_valid = 1;
      redirect_pc = 64'h200;
      arm(64'h200);
      tick();
      chk("clr_fault", 64'(fault), 64'h0);
      chk("clr_code", 64'(fault_code), 64'h0);
      redirect_valid = 0;
      tick();
      chk("clr_a", a, 64'h200);
      tick();
      chk("clr_pc", instr_pc, 64'h200);
      wait_n = 0;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("to_rd_n", 64'(rd_n), 64'h0);
         chk("to_fault", 64'(fault), 64'h0);
         tick();
      end
      chk("to_fault_set", 64'(fault), 64'h1);
      chk("to_code", 64'(fault_code), 64'h2);
      chk("to_rd_n_hi", 64'(rd_n), 64'h1);
      reset = 1;
      tick();
      chk_reset_outs();
      reset = 0;
      wait_n = 1;
      arm(64'h0);
      tick();
      chk("rs_a", a, 64'h0);
      chk("rs_rd_n", 64'(rd_n), 64'h0);
      tick();
      chk("rs_instr", 64'(instr), 64'h1111_2222);
      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
